// File: rtl/uart_tx_ctrl.sv
// rtl/uart_tx_ctrl.sv - UART transmit frame controller: start, data, optional parity, stop sequencing
module uart_tx_ctrl #(
    parameter int DATA_WD = 8
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         Data_Valid,
    input  logic                         PAR_EN,
    output logic                         data_load,
    output logic                         ser_en,
    output logic [1:0]                   mux_sel,
    output logic                         busy,
    output logic [$clog2(DATA_WD+1)-1:0] bit_cnt
);

    localparam int CNT_WD = $clog2(DATA_WD + 1);

    // Index of the last data bit; DATA is left once the counter reaches it.
    localparam logic [CNT_WD-1:0] LAST_BIT = CNT_WD'(DATA_WD - 1);

    // Line mux encodings.
    localparam logic [1:0] MUX_START  = 2'b00;
    localparam logic [1:0] MUX_DATA   = 2'b01;
    localparam logic [1:0] MUX_PARITY = 2'b10;
    localparam logic [1:0] MUX_STOP   = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [CNT_WD-1:0] bit_cnt_q;
    logic              par_en_r;
    logic              accept;

    // A request is only honoured while idle; anything else is dropped, not queued.
    assign accept    = Data_Valid && (state_q == S_IDLE);
    assign data_load = accept;
    assign bit_cnt   = bit_cnt_q;

    // State register; reset wins over a simultaneous request.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Parity enable is frozen at acceptance so later PAR_EN changes cannot alter the frame.
    always_ff @(posedge CLK) begin
        if (RST) begin
            par_en_r <= 1'b0;
        end else if (accept) begin
            par_en_r <= PAR_EN;
        end
    end

    // Data bit counter: advances only in DATA and returns to 0 on the last bit or elsewhere.
    always_ff @(posedge CLK) begin
        if (RST) begin
            bit_cnt_q <= '0;
        end else if ((state_q == S_DATA) && (bit_cnt_q != LAST_BIT)) begin
            bit_cnt_q <= bit_cnt_q + CNT_WD'(1);
        end else begin
            bit_cnt_q <= '0;
        end
    end

    // Next-state logic and Moore output decode from the current state.
    always_comb begin
        state_d = state_q;
        mux_sel = MUX_STOP;
        busy    = 1'b0;
        ser_en  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (Data_Valid) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                mux_sel = MUX_START;
                busy    = 1'b1;
                state_d = S_DATA;
            end
            S_DATA: begin
                mux_sel = MUX_DATA;
                busy    = 1'b1;
                ser_en  = 1'b1;
                if (bit_cnt_q == LAST_BIT) begin
                    state_d = par_en_r ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                mux_sel = MUX_PARITY;
                busy    = 1'b1;
                state_d = S_STOP;
            end
            S_STOP: begin
                mux_sel = MUX_STOP;
                busy    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb/tb_uart_tx_ctrl.sv - directed self-checking bench for uart_tx_ctrl
module tb_uart_tx_ctrl;

    logic       CLK;
    logic       RST;
    logic       Data_Valid;
    logic       PAR_EN;
    logic       data_load;
    logic       ser_en;
    logic [1:0] mux_sel;
    logic       busy;
    logic [3:0] bit_cnt;

    int vectors;
    int miscompares;
    int busy_cnt;

    uart_tx_ctrl #(.DATA_WD(8)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .data_load  (data_load),
        .ser_en     (ser_en),
        .mux_sel    (mux_sel),
        .busy       (busy),
        .bit_cnt    (bit_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Packed observation: {mux_sel, busy, ser_en, bit_cnt, data_load}
    function automatic logic [8:0] obs();
        return {mux_sel, busy, ser_en, bit_cnt, data_load};
    endfunction

    function automatic logic [8:0] ev(input logic [1:0] m, input logic b, input logic s,
                                      input int c, input logic d);
        return {m, b, s, 4'(c), d};
    endfunction

    // Expected outputs k cycles after acceptance (k=0 is START), DATA_WD=8.
    function automatic logic [8:0] fexp(input int k, input bit par);
        if (k == 0) return ev(2'b00, 1'b1, 1'b0, 0, 1'b0);
        if (k <= 8) return ev(2'b01, 1'b1, 1'b1, k - 1, 1'b0);
        if (par && k == 9) return ev(2'b10, 1'b1, 1'b0, 0, 1'b0);
        if (k == (par ? 10 : 9)) return ev(2'b11, 1'b1, 1'b0, 0, 1'b0);
        return ev(2'b11, 1'b0, 1'b0, 0, 1'b0);
    endfunction

    task automatic test_reset();
        RST = 1'b1;
        Data_Valid = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        Data_Valid = 1'b0;
        #1;
        vectors++;
        if (obs() !== ev(2'b11, 1'b0, 1'b0, 0, 1'b0)) begin
            miscompares++;
            $display("FAIL reset_idle got %b required %b", obs(), ev(2'b11, 1'b0, 1'b0, 0, 1'b0));
        end
        @(negedge CLK);
        #1;
        vectors++;
        if (obs() !== ev(2'b11, 1'b0, 1'b0, 0, 1'b0)) begin
            miscompares++;
            $display("FAIL reset_priority got %b required %b", obs(), ev(2'b11, 1'b0, 1'b0, 0, 1'b0));
        end
        @(negedge CLK);
    endtask

    task automatic test_frame(input bit par, input string name);
        busy_cnt = 0;
        PAR_EN = par;
        Data_Valid = 1'b1;
        #1;
        vectors++;
        if (obs() !== ev(2'b11, 1'b0, 1'b0, 0, 1'b1)) begin
            miscompares++;
            $display("FAIL %s_accept got %b required %b", name, obs(), ev(2'b11, 1'b0, 1'b0, 0, 1'b1));
        end
        @(negedge CLK);
        Data_Valid = 1'b0;
        for (int k = 0; k < 12; k++) begin
            #1;
            if (busy === 1'b1) busy_cnt++;
            vectors++;
            if (obs() !== fexp(k, par)) begin
                miscompares++;
                $display("FAIL %s k=%0d got %b required %b", name, k, obs(), fexp(k, par));
            end
            @(negedge CLK);
        end
        vectors++;
        if (busy_cnt !== (par ? 11 : 10)) begin
            miscompares++;
            $display("FAIL %s_busy_len got %0d required %0d", name, busy_cnt, par ? 11 : 10);
        end
    endtask

    task automatic test_busy_request();
        PAR_EN = 1'b1;
        Data_Valid = 1'b1;
        @(negedge CLK);
        Data_Valid = 1'b0;
        for (int k = 0; k < 13; k++) begin
            Data_Valid = (k == 4 || k == 10);
            #1;
            vectors++;
            if (obs() !== fexp(k, 1'b1)) begin
                miscompares++;
                $display("FAIL busy_req k=%0d got %b required %b", k, obs(), fexp(k, 1'b1));
            end
            @(negedge CLK);
        end
        Data_Valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [8:0] exp_v;
        int pos;
        busy_cnt = 0;
        PAR_EN = 1'b1;
        Data_Valid = 1'b1;
        for (int j = 0; j < 38; j++) begin
            if (j == 36) Data_Valid = 1'b0;
            #1;
            pos = j % 12;
            exp_v = (pos == 0) ? ev(2'b11, 1'b0, 1'b0, 0, (j < 36)) : fexp(pos - 1, 1'b1);
            if (j >= 36) exp_v = ev(2'b11, 1'b0, 1'b0, 0, 1'b0);
            if (busy === 1'b1) busy_cnt++;
            vectors++;
            if (obs() !== exp_v) begin
                miscompares++;
                $display("FAIL back_to_back j=%0d got %b required %b", j, obs(), exp_v);
            end
            @(negedge CLK);
        end
        vectors++;
        if (busy_cnt !== 33) begin
            miscompares++;
            $display("FAIL back_to_back_busy got %0d required 33", busy_cnt);
        end
    endtask

    task automatic test_reset_mid_frame();
        PAR_EN = 1'b1;
        Data_Valid = 1'b1;
        @(negedge CLK);
        Data_Valid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            #1;
            vectors++;
            if (obs() !== fexp(k, 1'b1)) begin
                miscompares++;
                $display("FAIL mid_reset_pre k=%0d got %b required %b", k, obs(), fexp(k, 1'b1));
            end
            if (k == 5) RST = 1'b1;
            @(negedge CLK);
        end
        RST = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            vectors++;
            if (obs() !== ev(2'b11, 1'b0, 1'b0, 0, 1'b0)) begin
                miscompares++;
                $display("FAIL mid_reset_idle k=%0d got %b required %b", k, obs(), ev(2'b11, 1'b0, 1'b0, 0, 1'b0));
            end
            @(negedge CLK);
        end
        test_frame(1'b1, "after_reset");
    endtask

    task automatic test_par_toggle();
        busy_cnt = 0;
        PAR_EN = 1'b1;
        Data_Valid = 1'b1;
        @(negedge CLK);
        Data_Valid = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (k == 3) PAR_EN = 1'b0;
            #1;
            if (busy === 1'b1) busy_cnt++;
            vectors++;
            if (obs() !== fexp(k, 1'b1)) begin
                miscompares++;
                $display("FAIL par_toggle k=%0d got %b required %b", k, obs(), fexp(k, 1'b1));
            end
            @(negedge CLK);
        end
        vectors++;
        if (busy_cnt !== 11) begin
            miscompares++;
            $display("FAIL par_toggle_busy got %0d required 11", busy_cnt);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        RST = 1'b1;
        Data_Valid = 1'b0;
        PAR_EN = 1'b0;
        repeat (3) @(negedge CLK);
        test_reset();
        test_frame(1'b1, "parity");
        test_frame(1'b0, "no_parity");
        test_busy_request();
        test_back_to_back();
        test_reset_mid_frame();
        test_par_toggle();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
